keypad_key_decoder: RTL
=======================

KEYPAD_KEY_DECODER -- requirements
Module: keypad_key_decoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive identical samples needed to accept a press or release (range 2..255).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 16: cycles in HELD before the first auto-repeat strobe.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 8: cycles between later auto-repeat strobes.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port code, input, 4 bits: key index from the keypad encoder.
REQ-007 The block SHALL have port valid, input, 1 bit: code qualifier from the keypad encoder.
REQ-008 The block SHALL have port key_strobe, output, 1 bit: one-cycle pulse per accepted keystroke.
REQ-009 The block SHALL have port key_onehot, output, 12 bits: one-hot of key_code, nonzero only while key_strobe=1.
REQ-010 The block SHALL have port key_code, output, 4 bits: last accepted key index, held between strobes.
REQ-011 The block SHALL have port key_held, output, 1 bit: high while in state HELD.
REQ-012 The block SHALL have port err_invalid, output, 1 bit: one-cycle pulse when a debounced code above 11 is rejected.

Function
REQ-013 The block SHALL implement the states IDLE, DEBOUNCE, HELD and RELEASE, with a candidate register cand[3:0] and an 8-bit counter cnt.
REQ-014 In IDLE, valid=1 SHALL load cand=code and cnt=1 and move to DEBOUNCE.
REQ-015 In DEBOUNCE, valid=0 SHALL return to IDLE with no output pulse.
REQ-016 In DEBOUNCE, valid=1 with code!=cand SHALL reload cand=code, set cnt=1 and stay in DEBOUNCE.
REQ-017 In DEBOUNCE, valid=1 with code==cand SHALL increment cnt.
REQ-018 When cnt reaches DEBOUNCE_CYCLES with cand<=11, the block SHALL register key_code=cand, pulse key_strobe and key_onehot[cand] for one cycle, and enter HELD.
REQ-019 When cnt reaches DEBOUNCE_CYCLES with cand>11, the block SHALL pulse err_invalid for one cycle, leave key_code unchanged, and enter RELEASE.
REQ-020 Latency SHALL be fixed: if valid rises with a stable code before edge 0, key_strobe SHALL be high in the cycle after edge DEBOUNCE_CYCLES-1.
REQ-021 In HELD, valid=0 or code!=key_code SHALL move to RELEASE with cnt=1 (counted only when valid=0).
REQ-022 A different key pressed while another is held SHALL NOT strobe until a full release followed by a new debounce.
REQ-023 In RELEASE, valid=0 SHALL increment cnt, and reaching DEBOUNCE_CYCLES SHALL enter IDLE.
REQ-024 In RELEASE, valid=1 with code==key_code SHALL return to HELD with no new strobe (bounce).
REQ-025 In RELEASE, valid=1 with any other code SHALL clear cnt and stay in RELEASE.
REQ-026 cnt SHALL saturate at DEBOUNCE_CYCLES and never wrap.
REQ-027 key_strobe and err_invalid SHALL never be high in the same cycle.

Reset
REQ-028 While rst=1, the block SHALL hold state=IDLE, cnt=0, cand=0, key_code=0, and key_strobe, key_onehot, key_held, err_invalid all 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard the pending keystroke, with no strobe during or after reset until a fresh full debounce.

Configuration
REQ-030 With KEY_REPEAT_EN defined, HELD SHALL run a 16-bit repeat counter: first re-strobe of key_code after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles; the counter clears on leaving HELD.
REQ-031 With KEY_REPEAT_EN undefined, the block SHALL emit exactly one strobe per press, contain no repeat counter, and ignore REPEAT_DELAY and REPEAT_PERIOD.

Structure
REQ-032 The state encodings, the key count (12) and the maximum valid index (11) SHALL live in team_params_202500415_202502112.vh and be included by this block.
REQ-033 A single sub-module, key_debounce_counter (saturating counter with load, clear and increment), SHALL be used by both DEBOUNCE and RELEASE.

Verification
REQ-034 Test: code=5, valid=1 held 10 cycles (N=4) -> one key_strobe in cycle 4, key_onehot=12'h020, key_code=5, key_held=1 from cycle 4.
REQ-035 Test: code toggling 3/7 every 2 cycles, then 7 held stable -> no strobe during toggling; a single strobe with key_code=7 four cycles after stabilisation.
REQ-036 Test: code=14, valid=1 held 6 cycles -> err_invalid pulse in cycle 4, no key_strobe, key_code unchanged.
REQ-037 Test: key 2 held, then valid dropped for 2 cycles, then key 2 returns -> remains HELD, no second strobe; valid=0 for 4 cycles -> IDLE.
REQ-038 Test: rst asserted in the cycle that debounce completes for key 9 -> no strobe; all outputs 0 the next cycle.
REQ-039 Test (KEY_REPEAT_EN defined): key 1 held for 40 cycles -> strobes at cycles 4, 20, 28 and 36.

Source files
------------

// File: rtl/keypad_key_decoder_pkg.sv
// keypad_key_decoder_pkg
//   Types and constants shared by the keypad decoder, its interface and
//   its debounce counter. Pulls in the shared team parameter header.
//   Contents: state_t (FSM states), CNT_W (debounce counter width),
//   REP_W (auto-repeat counter width), key_to_onehot() helper.
package keypad_key_decoder_pkg;
`include "team_params_202500415_202502112.vh"

   localparam int CNT_W = 8;
   localparam int REP_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = ST_IDLE_ENC,
      ST_DEBOUNCE = ST_DEBOUNCE_ENC,
      ST_HELD     = ST_HELD_ENC,
      ST_RELEASE  = ST_RELEASE_ENC
   } state_t;

   // Only called with indices already known to be <= MAX_KEY_IDX.
   function automatic logic [KEY_COUNT-1:0] key_to_onehot(input logic [3:0] idx);
      key_to_onehot = KEY_COUNT'(1) << idx;
   endfunction
endpackage

// File: rtl/keypad_key_decoder_if.sv
// keypad_key_decoder_if
//   Bundles the keypad encoder side (code/valid) and the decoded key
//   outputs of keypad_key_decoder.
//   master : keypad encoder / consumer side (drives code, valid)
//   slave  : the decoder (drives key_strobe, key_onehot, key_code,
//            key_held, err_invalid)
interface keypad_key_decoder_if;
   import keypad_key_decoder_pkg::*;

   logic [3:0]           code;
   logic                 valid;
   logic                 key_strobe;
   logic [KEY_COUNT-1:0] key_onehot;
   logic [3:0]           key_code;
   logic                 key_held;
   logic                 err_invalid;

   modport master (
      output code, valid,
      input  key_strobe, key_onehot, key_code, key_held, err_invalid
   );

   modport slave (
      input  code, valid,
      output key_strobe, key_onehot, key_code, key_held, err_invalid
   );
endinterface

// File: rtl/keypad_key_decoder_counter.sv
// key_debounce_counter
//   Saturating 8-bit counter shared by the DEBOUNCE and RELEASE phases.
//   Ports: clk, rst (sync, active-high)
//          i_clr  : force count to 0 (highest priority)
//          i_load : force count to 1 (first matching sample)
//          i_inc  : add one, saturating at LIMIT
//          o_last : count is LIMIT-1 or more, so one more matching
//                   sample completes the debounce window
module key_debounce_counter #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_inc,
   output logic o_last
);
   import keypad_key_decoder_pkg::*;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(1);
      end else if (i_inc && (r_cnt < CNT_W'(LIMIT))) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_last = (r_cnt >= CNT_W'(LIMIT - 1));
endmodule

// File: rtl/team_params_202500415_202502112.vh
// Shared keypad constants: FSM state encodings, number of physical keys and
// the highest key index a debounced code may carry and still be accepted.
`ifndef TEAM_PARAMS_202500415_202502112_VH
`define TEAM_PARAMS_202500415_202502112_VH
localparam logic [1:0]  ST_IDLE_ENC     = 2'd0;
localparam logic [1:0]  ST_DEBOUNCE_ENC = 2'd1;
localparam logic [1:0]  ST_HELD_ENC     = 2'd2;
localparam logic [1:0]  ST_RELEASE_ENC  = 2'd3;
localparam int          KEY_COUNT       = 12;
localparam logic [3:0]  MAX_KEY_IDX     = 4'd11;
`endif

// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder
//   Debounces the code/valid stream from a keypad encoder and emits one
//   strobe (plus one-hot) per accepted key press. Codes above 11 that
//   survive debounce raise a one-cycle err_invalid instead.
//   Ports: clk, rst (sync, active-high), kp (keypad_key_decoder_if.slave)
//   Optional feature macro: KEY_REPEAT_EN -- when defined, a held key
//   re-strobes after REPEAT_DELAY cycles and then every REPEAT_PERIOD.
//   Latency: a code that is stable from edge 0 strobes after edge
//   DEBOUNCE_CYCLES-1.
module keypad_key_decoder
   import keypad_key_decoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 16,
   parameter int unsigned REPEAT_PERIOD   = 8
) (
   input logic                 clk,
   input logic                 rst,
   keypad_key_decoder_if.slave kp
);
   state_t               r_state, w_state_next;
   logic [3:0]           r_cand, w_cand_next;
   logic [3:0]           r_key_code, w_key_code_next;
   logic                 r_strobe, w_strobe_next;
   logic [KEY_COUNT-1:0] r_onehot, w_onehot_next;
   logic                 r_err, w_err_next;
   logic                 w_cnt_clr, w_cnt_load, w_cnt_inc, w_cnt_last;
`ifdef KEY_REPEAT_EN
   logic [REP_W-1:0]     r_rep, w_rep_next;
`endif

   key_debounce_counter #(.LIMIT(DEBOUNCE_CYCLES)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_load (w_cnt_load),
      .i_inc  (w_cnt_inc),
      .o_last (w_cnt_last)
   );

   always_comb begin
      w_state_next    = r_state;
      w_cand_next     = r_cand;
      w_key_code_next = r_key_code;
      w_strobe_next   = 1'b0;
      w_onehot_next   = '0;
      w_err_next      = 1'b0;
      w_cnt_clr       = 1'b0;
      w_cnt_load      = 1'b0;
      w_cnt_inc       = 1'b0;
`ifdef KEY_REPEAT_EN
      w_rep_next      = '0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (kp.valid) begin
               w_cand_next  = kp.code;
               w_cnt_load   = 1'b1;
               w_state_next = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!kp.valid) begin
               w_cnt_clr    = 1'b1;
               w_state_next = ST_IDLE;
            end else if (kp.code != r_cand) begin
               w_cand_next = kp.code;
               w_cnt_load  = 1'b1;
            end else if (w_cnt_last) begin
               // Window complete: accept a real key, reject anything else.
               w_cnt_clr = 1'b1;
               if (r_cand <= MAX_KEY_IDX) begin
                  w_key_code_next = r_cand;
                  w_strobe_next   = 1'b1;
                  w_onehot_next   = key_to_onehot(r_cand);
                  w_state_next    = ST_HELD;
               end else begin
                  w_err_next   = 1'b1;
                  w_state_next = ST_RELEASE;
               end
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         ST_HELD: begin
            if (!kp.valid) begin
               w_cnt_load   = 1'b1;
               w_state_next = ST_RELEASE;
            end else if (kp.code != r_key_code) begin
               // A different key is not a release sample; wait for valid=0.
               w_cnt_clr    = 1'b1;
               w_state_next = ST_RELEASE;
`ifdef KEY_REPEAT_EN
            end else if ((r_rep + REP_W'(1)) == REP_W'(REPEAT_DELAY)) begin
               // Rewind so the next hit is REPEAT_PERIOD cycles away.
               w_strobe_next = 1'b1;
               w_onehot_next = key_to_onehot(r_key_code);
               w_rep_next    = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
               w_rep_next = r_rep + REP_W'(1);
`endif
            end
         end
         ST_RELEASE: begin
            if (!kp.valid) begin
               if (w_cnt_last) begin
                  w_cnt_clr    = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end else if (kp.code == r_key_code) begin
               // Contact bounce on the held key: resume holding silently.
               w_cnt_clr    = 1'b1;
               w_state_next = ST_HELD;
            end else begin
               w_cnt_clr = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cand     <= '0;
         r_key_code <= '0;
         r_strobe   <= 1'b0;
         r_onehot   <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cand     <= w_cand_next;
         r_key_code <= w_key_code_next;
         r_strobe   <= w_strobe_next;
         r_onehot   <= w_onehot_next;
         r_err      <= w_err_next;
      end
   end

`ifdef KEY_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep <= '0;
      end else begin
         r_rep <= w_rep_next;
      end
   end
`endif

   assign kp.key_strobe  = r_strobe;
   assign kp.key_onehot  = r_onehot;
   assign kp.key_code    = r_key_code;
   assign kp.key_held    = (r_state == ST_HELD);
   assign kp.err_invalid = r_err;
endmodule
